// File: rtl/fifo_uart_tx.sv
// UART-style serial transmitter that pops words from an async FIFO read port.
// Optional parity bit is compiled in when the PARITY_EN macro is defined.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_EN,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_R_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  if (CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2 and PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [IW-1:0]         data_idx, data_idx_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic                  tx_n;
  logic                  tick;
  logic                  pop;
`ifdef PARITY_EN
  logic                  par_bit, par_n;
`endif

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    tick       = (bit_cnt == CNT_LAST);
    pop        = TX_EN & ~FIFO_EMPTY & ~RST &
                 ((state == S_IDLE) | ((state == S_STOP) & tick));
    FIFO_R_INC = pop;

    state_n    = state;
    shift_n    = shift_reg;
    data_idx_n = data_idx;
    bit_cnt_n  = (tick || state == S_IDLE) ? '0 : bit_cnt + CNT_ONE;
`ifdef PARITY_EN
    par_n      = par_bit;
`endif

    unique case (state)
      S_IDLE:  ;
      S_START: if (tick) state_n = S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_n    = shift_reg >> 1;
          data_idx_n = data_idx + IDX_ONE;
          if (data_idx == IDX_LAST) begin
            data_idx_n = '0;
`ifdef PARITY_EN
            state_n    = S_PARITY;
`else
            state_n    = S_STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      S_PARITY: if (tick) state_n = S_STOP;
`endif
      S_STOP:  if (tick) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // A pop only happens from IDLE or the last stop-bit cycle, so it simply
    // overrides whatever the case statement chose and starts a new frame.
    if (pop) begin
      state_n    = S_START;
      shift_n    = FIFO_RD_DATA;
      data_idx_n = '0;
`ifdef PARITY_EN
      par_n      = (^FIFO_RD_DATA) ^ (PARITY_ODD != 0);
`endif
    end

    if (state_n != state) bit_cnt_n = '0;

    // Line level is computed from the next state so TX_OUT can be a flop.
    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
`ifdef PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the datapath registers are reset too; they are a handful of
      // flops, not a memory, and a clean reset avoids X on TX_OUT.
      state     <= S_IDLE;
      bit_cnt   <= '0;
      data_idx  <= '0;
      shift_reg <= '0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
`ifdef PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      data_idx  <= data_idx_n;
      shift_reg <= shift_n;
      TX_OUT    <= tx_n;
      BUSY      <= (state_n != S_IDLE);
`ifdef PARITY_EN
      par_bit   <= par_n;
`endif
    end
  end

endmodule
